// File: rtl/lsp_cb_decode_expand.sv
// rtl/lsp_cb_decode_expand.sv - parametrised LSP codebook decode with gap expansion
module lsp_cb_decode_expand #(
  parameter int          M        = 10,
  parameter int          NC       = 5,
  parameter int          NUM_GAPS = 2,
  parameter logic [15:0] GAP1     = 16'd10,
  parameter logic [15:0] GAP2     = 16'd5,
  parameter logic [11:0] CB1_BASE = 12'h000,
  parameter logic [11:0] CB2_BASE = 12'h800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] code0,
  input  logic [15:0] code1,
  input  logic [15:0] code2,
  input  logic [11:0] bufAddr,
  input  logic [31:0] constantMemIn,
  output logic [11:0] constantMemAddr,
  output logic [31:0] memOut,
  output logic [11:0] memWriteAddr,
  output logic        memWriteEn,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH2, S_FETCH1, S_SUM, S_EXPAND, S_WRITE, S_DONE
  } state_t;

  localparam logic [3:0]  LAST_J  = 4'(M - 1);
  localparam logic [3:0]  SPLIT_J = 4'(NC);
  localparam logic [11:0] ROW_LEN = 12'(M);
  localparam logic [1:0]  PASSES  = 2'(NUM_GAPS);

  state_t             state, state_nx;
  logic [3:0]         j;
  logic [1:0]         pass;
  logic [6:0]         row0;
  logic [4:0]         row1, row2;
  logic [11:0]        base_q;
  logic signed [15:0] cb2_word;
  logic signed [15:0] rf [16];

  logic [4:0]         row_x;
  logic [11:0]        addr_cb2, addr_cb1;
  logic [3:0]         jm1;
  logic signed [15:0] cb1_word, sum_val, prev, cur, gap, diff, gsum, tstep, prev_nx, cur_nx;
  logic               step_on;

  logic unused_inputs;
  assign unused_inputs = ^{constantMemIn[31:16], code0[15:7], code1[15:5], code2[15:5]};

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)
      return 16'sh7FFF;
    else if (v < -17'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // Row addressing, codebook sum and one expansion step on the current j
  always_comb begin
    row_x    = (j < SPLIT_J) ? row1 : row2;
    addr_cb2 = CB2_BASE + ROW_LEN * {7'd0, row_x} + {8'd0, j};
    addr_cb1 = CB1_BASE + ROW_LEN * {5'd0, row0} + {8'd0, j};
    cb1_word = constantMemIn[15:0];
    sum_val  = sat16({cb1_word[15], cb1_word} + {cb2_word[15], cb2_word});
    jm1      = j - 4'd1;
    prev     = rf[jm1];
    cur      = rf[j];
    gap      = (pass == 2'd1) ? GAP1 : GAP2;
    diff     = sat16({prev[15], prev} - {cur[15], cur});
    gsum     = sat16({diff[15], diff} + {gap[15], gap});
    tstep    = gsum >>> 1;
    step_on  = (tstep > 16'sd0);
    prev_nx  = sat16({prev[15], prev} - {tstep[15], tstep});
    cur_nx   = sat16({cur[15], cur} + {tstep[15], tstep});
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next-state and output decode
  always_comb begin
    state_nx        = state;
    constantMemAddr = '0;
    memOut          = '0;
    memWriteAddr    = '0;
    memWriteEn      = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_FETCH2;
      end
      S_FETCH2: begin
        constantMemAddr = addr_cb2;
        state_nx        = S_FETCH1;
      end
      S_FETCH1: begin
        constantMemAddr = addr_cb1;
        state_nx        = S_SUM;
      end
      S_SUM: begin
        if (j == LAST_J)
          state_nx = (PASSES == 2'd0) ? S_WRITE : S_EXPAND;
        else
          state_nx = S_FETCH2;
      end
      S_EXPAND: begin
        if (j == LAST_J && pass == PASSES) state_nx = S_WRITE;
      end
      S_WRITE: begin
        memWriteEn   = 1'b1;
        memWriteAddr = base_q + {8'd0, j};
        memOut       = {{16{cur[15]}}, cur};
        if (j == LAST_J) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Index, pass counter, latched request and the buf register file
  always_ff @(posedge clk) begin
    if (reset) begin
      j        <= '0;
      pass     <= '0;
      cb2_word <= '0;
      row0     <= '0;
      row1     <= '0;
      row2     <= '0;
      base_q   <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          j    <= '0;
          pass <= '0;
          for (int i = 0; i < 16; i++) rf[i] <= '0;
          if (start) begin
            row0   <= code0[6:0];
            row1   <= code1[4:0];
            row2   <= code2[4:0];
            base_q <= bufAddr;
          end
        end
        S_FETCH1: cb2_word <= constantMemIn[15:0];
        S_SUM: begin
          rf[j] <= sum_val;
          if (j == LAST_J) begin
            if (PASSES == 2'd0) begin
              j <= '0;
            end else begin
              j    <= 4'd1;
              pass <= 2'd1;
            end
          end else begin
            j <= j + 4'd1;
          end
        end
        S_EXPAND: begin
          if (step_on) begin
            rf[jm1] <= prev_nx;
            rf[j]   <= cur_nx;
          end
          if (j == LAST_J) begin
            if (pass == PASSES) begin
              j <= '0;
            end else begin
              j    <= 4'd1;
              pass <= pass + 2'd1;
            end
          end else begin
            j <= j + 4'd1;
          end
        end
        S_WRITE: j <= (j == LAST_J) ? 4'd0 : j + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsp_cb_decode_expand.sv
// tb/tb_lsp_cb_decode_expand.sv - scoreboard bench for lsp_cb_decode_expand
module tb_lsp_cb_decode_expand;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start [2];
  logic [15:0] code0, code1, code2;
  logic [11:0] buf_addr;
  logic [31:0] cm_in [2];
  logic [11:0] cm_addr [2];
  logic [31:0] mem_out [2];
  logic [11:0] wr_addr [2];
  logic        we [2];
  logic        busy [2];
  logic        done [2];

  // instance 0: default parameters; instance 1: M=4, NC=2, no expansion
  lsp_cb_decode_expand dut0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .code0(code0), .code1(code1), .code2(code2), .bufAddr(buf_addr),
    .constantMemIn(cm_in[0]), .constantMemAddr(cm_addr[0]),
    .memOut(mem_out[0]), .memWriteAddr(wr_addr[0]), .memWriteEn(we[0]),
    .busy(busy[0]), .done(done[0])
  );

  lsp_cb_decode_expand #(.M(4), .NC(2), .NUM_GAPS(0)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .code0(code0), .code1(code1), .code2(code2), .bufAddr(buf_addr),
    .constantMemIn(cm_in[1]), .constantMemAddr(cm_addr[1]),
    .memOut(mem_out[1]), .memWriteAddr(wr_addr[1]), .memWriteEn(we[1]),
    .busy(busy[1]), .done(done[1])
  );

  // constant memory with one-cycle read latency; upper half is noise
  logic [15:0] cmem [4096];
  always @(posedge clk) begin
    cm_in[0] <= {16'($urandom), cmem[cm_addr[0]]};
    cm_in[1] <= {16'($urandom), cmem[cm_addr[1]]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    int          cyc;
    int          j;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t addr_q[$];
  ev_t wr_q[$];
  ev_t done_q[$];

  logic [31:0] got [2][16];
  int          done_cyc [2];
  int          total = 0;
  int          bad = 0;

  task automatic chk(string name, logic [31:0] got_v, logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got_v, exp_v, cyc);
    end
  endtask

  // monitor: compares DUT outputs against the expectation queues
  always @(negedge clk) begin
    ev_t ev;
    bit  exp_on;
    if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
      ev = addr_q.pop_front();
      chk("const_addr", 32'(cm_addr[ev.inst]), 32'(ev.addr));
    end
    for (int i = 0; i < 2; i++) begin
      exp_on = (wr_q.size() > 0 && wr_q[0].inst == i && wr_q[0].cyc == cyc);
      if (we[i] || exp_on) begin
        chk("write_en", 32'(we[i]), 32'(exp_on));
        if (exp_on) begin
          ev = wr_q.pop_front();
          chk("write_addr", 32'(wr_addr[i]), 32'(ev.addr));
          chk("write_data", mem_out[i], ev.data);
          got[i][ev.j] = mem_out[i];
        end
      end
      exp_on = (done_q.size() > 0 && done_q[0].inst == i && done_q[0].cyc == cyc);
      if (done[i]) done_cyc[i] = cyc;
      if (done[i] || exp_on) begin
        chk("done", 32'(done[i]), 32'(exp_on));
        if (exp_on) void'(done_q.pop_front());
      end
    end
  end

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int s16(logic [15:0] x);
    return int'($signed(x));
  endfunction

  // reference model: buf from the codebook rules, then expected bus activity
  task automatic expect_txn(int inst, logic [15:0] c0, logic [15:0] c1, logic [15:0] c2,
                            logic [11:0] ba, int sc, int cut);
    int  m, nc, ng, r0, rx, a1, a2, gap, d, s, t, wbase;
    int  b [16];
    ev_t ev;
    m  = (inst == 0) ? 10 : 4;
    nc = (inst == 0) ? 5 : 2;
    ng = (inst == 0) ? 2 : 0;
    r0 = int'(c0) % 128;
    for (int j = 0; j < m; j++) begin
      rx = (j < nc) ? int'(c1) % 32 : int'(c2) % 32;
      a2 = (2048 + rx * m + j) % 4096;
      a1 = (r0 * m + j) % 4096;
      b[j] = clamp16(s16(cmem[a1]) + s16(cmem[a2]));
      ev.inst = inst; ev.j = j; ev.data = '0;
      if (3 * j < cut)     begin ev.cyc = sc + 3 * j;     ev.addr = 12'(a2); addr_q.push_back(ev); end
      if (3 * j + 1 < cut) begin ev.cyc = sc + 3 * j + 1; ev.addr = 12'(a1); addr_q.push_back(ev); end
    end
    for (int p = 1; p <= ng; p++) begin
      gap = (p == 1) ? 10 : 5;
      for (int j = 1; j < m; j++) begin
        d = clamp16(b[j-1] - b[j]);
        s = clamp16(d + gap);
        if (s >= 2) begin
          t = s / 2;
          b[j-1] = clamp16(b[j-1] - t);
          b[j]   = clamp16(b[j] + t);
        end
      end
    end
    wbase = 3 * m + ng * (m - 1);
    for (int j = 0; j < m; j++) begin
      if (wbase + j < cut) begin
        ev.inst = inst; ev.cyc = sc + wbase + j; ev.j = j;
        ev.addr = 12'(int'(ba) + j); ev.data = b[j];
        wr_q.push_back(ev);
      end
    end
    if (wbase + m < cut) begin
      ev.inst = inst; ev.cyc = sc + wbase + m; ev.j = 0; ev.addr = '0; ev.data = '0;
      done_q.push_back(ev);
    end
  endtask

  task automatic check_idle(int inst);
    chk("idle_busy", 32'(busy[inst]), 32'd0);
    chk("idle_done", 32'(done[inst]), 32'd0);
    chk("idle_we", 32'(we[inst]), 32'd0);
    chk("idle_const_addr", 32'(cm_addr[inst]), 32'd0);
    chk("idle_mem_out", mem_out[inst], 32'd0);
    chk("idle_write_addr", 32'(wr_addr[inst]), 32'd0);
  endtask

  task automatic issue(int inst, logic [15:0] c0, logic [15:0] c1, logic [15:0] c2,
                       logic [11:0] ba, output int sc);
    @(negedge clk);
    code0 = c0; code1 = c1; code2 = c2; buf_addr = ba;
    start[inst] = 1'b1;
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
    sc = cyc;
    chk("busy_after_start", 32'(busy[inst]), 32'd1);
  endtask

  task automatic drain(int limit);
    int k;
    k = 0;
    while ((wr_q.size() + done_q.size() + addr_q.size()) != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 32'(wr_q.size() + done_q.size() + addr_q.size()), 32'd0);
    wr_q.delete(); done_q.delete(); addr_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_txn(int inst, logic [15:0] c0, logic [15:0] c1, logic [15:0] c2,
                         logic [11:0] ba, output int sc);
    issue(inst, c0, c1, c2, ba, sc);
    expect_txn(inst, c0, c1, c2, ba, sc, 1 << 30);
    drain(300);
    check_idle(inst);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 4096; a++)
      cmem[a] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1200)) - 16'd600;
  endtask

  initial begin
    int sc;
    int c0r, c1r, c2r, bar;
    reset = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    code0 = '0; code1 = '0; code2 = '0; buf_addr = '0;
    fill_random();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle(0);
    check_idle(1);

    // rising rows, zero cb2: nothing moves, latency 58
    for (int j = 0; j < 10; j++) begin
      cmem[30 + j]         = 16'(1000 * (j + 1));
      cmem[12'h800 + 70 + j] = 16'd0;
    end
    run_txn(0, 16'd3, 16'd7, 16'd7, 12'h100, sc);
    chk("t1_latency", 32'(done_cyc[0] - sc), 32'd58);
    chk("t1_buf0", got[0][0], 32'd1000);
    chk("t1_buf9", got[0][9], 32'd10000);

    // close pair at the front gets pushed apart by pass 1 only
    cmem[0] = 16'd100; cmem[1] = 16'd95; cmem[2] = 16'd2000;
    for (int j = 3; j < 10; j++) cmem[j] = 16'(1000 * j);
    for (int j = 0; j < 10; j++) cmem[12'h800 + j] = 16'd0;
    run_txn(0, 16'd0, 16'd0, 16'd0, 12'h200, sc);
    chk("t2_buf0", got[0][0], 32'd93);
    chk("t2_buf1", got[0][1], 32'd102);
    chk("t2_buf2", got[0][2], 32'd2000);
    chk("t2_buf9", got[0][9], 32'd9000);

    // saturation at both ends
    cmem[50] = 16'hFC18 - 16'd31000;
    for (int j = 1; j < 9; j++) cmem[50 + j] = 16'(1000 * j);
    cmem[59] = 16'd32000;
    for (int j = 0; j < 10; j++) cmem[12'h800 + 40 + j] = 16'd0;
    cmem[12'h800 + 40] = 16'hFC18;
    cmem[12'h800 + 49] = 16'd1000;
    run_txn(0, 16'd5, 16'd4, 16'd4, 12'hFFC, sc);
    chk("t3_neg_sat", got[0][0], 32'hFFFF8000);
    chk("t3_pos_sat", got[0][9], 32'h00007FFF);

    // split rows: distinct code1/code2 with address checks each fetch
    fill_random();
    run_txn(0, 16'd11, 16'd2, 16'd9, 12'h345, sc);

    // second start while busy is ignored, reset mid-expansion aborts
    issue(0, 16'd17, 16'd1, 16'd3, 12'h080, sc);
    expect_txn(0, 16'd17, 16'd1, 16'd3, 12'h080, sc, 40);
    while (cyc < sc + 9) @(negedge clk);
    code0 = 16'd40; code1 = 16'd20; code2 = 16'd30; buf_addr = 12'h600;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    while (cyc < sc + 39) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("t5_no_write", 32'(we[0]), 32'd0);
      chk("t5_no_done", 32'(done[0]), 32'd0);
    end
    chk("t5_addr_pending", 32'(addr_q.size()), 32'd0);
    addr_q.delete();
    check_idle(0);

    // small configuration without expansion: raw sums, latency 16
    for (int j = 0; j < 4; j++) cmem[4 + j] = 16'(10 * (j + 1));
    cmem[12'h80C] = 16'd1; cmem[12'h80D] = 16'd2;
    cmem[12'h81A] = 16'd3; cmem[12'h81B] = 16'd4;
    run_txn(1, 16'd1, 16'd3, 16'd6, 12'h010, sc);
    chk("t6_latency", 32'(done_cyc[1] - sc), 32'd16);
    chk("t6_buf0", got[1][0], 32'd11);
    chk("t6_buf1", got[1][1], 32'd22);
    chk("t6_buf2", got[1][2], 32'd33);
    chk("t6_buf3", got[1][3], 32'd44);

    // randomized transactions on both configurations
    for (int n = 0; n < 12; n++) begin
      fill_random();
      c0r = int'($urandom_range(0, 65535));
      c1r = int'($urandom_range(0, 65535));
      c2r = int'($urandom_range(0, 65535));
      bar = int'($urandom_range(0, 4095));
      run_txn(n % 2, 16'(c0r), 16'(c1r), 16'(c2r), 12'(bar), sc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
